// File: rtl/pe_grid_pkg.sv
// Shared types for the PE grid engine: opcodes, FSM states, shift
// directions and the flat-bus index helper.
// Optional feature macro used by the grid: PE_GRID_SATURATE_EN.
package pe_grid_pkg;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_LOAD_A    = 3'd1,
        OP_LOAD_B    = 3'd2,
        OP_LOAD_S    = 3'd3,
        OP_SHIFT     = 3'd4,
        OP_MAC       = 3'd5,
        OP_CLEAR_S   = 3'd6,
        OP_SHIFT_MAC = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    // LSB position of element (r,c) in a row-major flat bus of w-bit elements
    function automatic int flat_lsb(input int r, input int c, input int cols, input int w);
        return (r * cols + c) * w;
    endfunction

endpackage

// File: rtl/pe_grid_engine_cell.sv
// One grid cell: A/B/S registers, a four-neighbour shift mux (edge zeros are
// tied off by the parent) and the multiply-accumulate.
// PE_GRID_SATURATE_EN: accumulate saturates instead of wrapping.
module pe_grid_cell
    import pe_grid_pkg::*;
#(
    parameter int PRECISION        = 8,
    parameter int OUTPUT_PRECISION = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_a,
    input  logic                        load_b,
    input  logic                        load_s,
    input  logic                        clear_s,
    input  logic                        mac_en,
    input  logic                        shift_en,
    input  logic                        shift_sel,
    input  logic [1:0]                  dir,
    input  logic [PRECISION-1:0]        a_ld,
    input  logic [PRECISION-1:0]        b_ld,
    input  logic [OUTPUT_PRECISION-1:0] s_ld,
    input  logic [PRECISION-1:0]        a_above,
    input  logic [PRECISION-1:0]        a_below,
    input  logic [PRECISION-1:0]        a_left,
    input  logic [PRECISION-1:0]        a_right,
    input  logic [PRECISION-1:0]        b_above,
    input  logic [PRECISION-1:0]        b_below,
    input  logic [PRECISION-1:0]        b_left,
    input  logic [PRECISION-1:0]        b_right,
    output logic [PRECISION-1:0]        a,
    output logic [PRECISION-1:0]        b,
    output logic [OUTPUT_PRECISION-1:0] s
);

    logic [PRECISION-1:0]          a_nb;
    logic [PRECISION-1:0]          b_nb;
    logic signed [2*PRECISION-1:0] prod;
    logic [OUTPUT_PRECISION-1:0]   prod_ext;
    logic [OUTPUT_PRECISION-1:0]   s_mac;

    // Pick the neighbour whose value moves into this cell for the current direction
    always_comb begin
        a_nb = '0;
        b_nb = '0;
        case (dir)
            DIR_UP:    begin a_nb = a_below; b_nb = b_below; end
            DIR_DOWN:  begin a_nb = a_above; b_nb = b_above; end
            DIR_LEFT:  begin a_nb = a_right; b_nb = b_right; end
            default:   begin a_nb = a_left;  b_nb = b_left;  end
        endcase
    end

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = OUTPUT_PRECISION'(prod);

`ifdef PE_GRID_SATURATE_EN
    logic [OUTPUT_PRECISION:0] sum_wide;

    // One guard bit detects signed overflow; clamp to the signed extreme
    always_comb begin
        sum_wide = {s[OUTPUT_PRECISION-1], s} + {prod_ext[OUTPUT_PRECISION-1], prod_ext};
        s_mac    = sum_wide[OUTPUT_PRECISION-1:0];
        if (sum_wide[OUTPUT_PRECISION] != sum_wide[OUTPUT_PRECISION-1]) begin
            s_mac = sum_wide[OUTPUT_PRECISION] ? {1'b1, {(OUTPUT_PRECISION-1){1'b0}}}
                                               : {1'b0, {(OUTPUT_PRECISION-1){1'b1}}};
        end
    end
`else
    // Modular accumulate
    always_comb begin
        s_mac = s + prod_ext;
    end
`endif

    // A register: load or shift-in from the selected neighbour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      a <= '0;
        else if (load_a)                 a <= a_ld;
        else if (shift_en && !shift_sel) a <= a_nb;
    end

    // B register: load or shift-in from the selected neighbour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                     b <= '0;
        else if (load_b)                b <= b_ld;
        else if (shift_en && shift_sel) b <= b_nb;
    end

    // Accumulator: load, clear or accumulate A*B
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       s <= '0;
        else if (load_s)  s <= s_ld;
        else if (clear_s) s <= '0;
        else if (mac_en)  s <= s_mac;
    end

endmodule

// File: rtl/pe_grid_engine.sv
// ROWS x COLS processing grid with a command FSM sequencing multi-step
// shift and shift-then-accumulate operations.
// PE_GRID_SATURATE_EN: cells saturate the accumulate instead of wrapping.
//
// Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
// cmd_ready is high only in IDLE and is decoded from registered state, so it
// never depends on cmd_valid; valid offered while not ready is simply dropped.
module pe_grid_engine
    import pe_grid_pkg::*;
#(
    parameter  int ROWS             = 4,
    parameter  int COLS             = 4,
    parameter  int PRECISION        = 8,
    parameter  int OUTPUT_PRECISION = 32,
    parameter  int MAX_SHIFT        = 4,
    localparam int CW               = $clog2(MAX_SHIFT + 1)
) (
    input  logic                                  CLK,
    input  logic                                  RST_N,
    input  logic                                  cmd_valid,
    output logic                                  cmd_ready,
    input  logic [2:0]                            cmd,
    input  logic [1:0]                            shift_direction,
    input  logic                                  image_to_shift,
    input  logic [CW-1:0]                         shift_count,
    input  logic [ROWS*COLS*PRECISION-1:0]        a_load,
    input  logic [ROWS*COLS*PRECISION-1:0]        b_load,
    input  logic [ROWS*COLS*OUTPUT_PRECISION-1:0] s_load,
    output logic [ROWS*COLS*PRECISION-1:0]        A_out,
    output logic [ROWS*COLS*PRECISION-1:0]        B_out,
    output logic [ROWS*COLS*OUTPUT_PRECISION-1:0] s_out,
    output logic                                  done,
    output logic                                  busy,
    output logic [1:0]                            state_dbg
);

    localparam int SW = $clog2(2 * MAX_SHIFT + 1);

    opcode_t         op_in, op_eff, op_q;
    state_t          state_q, state_d;
    logic [1:0]      dir_q;
    logic            sel_q, phase_q;
    logic [CW-1:0]   n_clamped;
    logic [SW-1:0]   k_eff, steps_q;
    logic            accept, exec;
    logic            ld_a, ld_b, ld_s, clr_s, shift_en, mac_en;

    logic [PRECISION-1:0]        a_q [ROWS][COLS];
    logic [PRECISION-1:0]        b_q [ROWS][COLS];
    logic [OUTPUT_PRECISION-1:0] s_q [ROWS][COLS];

    assign op_in  = opcode_t'(cmd);
    assign accept = (state_q == ST_IDLE) && cmd_valid;
    assign exec   = (state_q == ST_EXEC);

    // Clamp the count and fold N=0 shifts into their single-edge equivalents
    always_comb begin
        n_clamped = (shift_count > CW'(MAX_SHIFT)) ? CW'(MAX_SHIFT) : shift_count;
        op_eff    = op_in;
        k_eff     = SW'(1);
        if (op_in == OP_SHIFT) begin
            if (n_clamped == '0) op_eff = OP_NOP;
            else                 k_eff  = SW'(n_clamped);
        end else if (op_in == OP_SHIFT_MAC) begin
            if (n_clamped == '0) op_eff = OP_MAC;
            else                 k_eff  = SW'(n_clamped) << 1;
        end
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state and status outputs
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        state_dbg = state_q;
        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_d = ST_EXEC;
            end
            ST_EXEC: if (steps_q == SW'(1)) state_d = ST_DONE;
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Command capture and step/phase counting while executing
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q    <= OP_NOP;
            dir_q   <= DIR_UP;
            sel_q   <= 1'b0;
            steps_q <= '0;
            phase_q <= 1'b0;
        end else if (accept) begin
            op_q    <= op_eff;
            dir_q   <= shift_direction;
            sel_q   <= image_to_shift;
            steps_q <= k_eff;
            phase_q <= 1'b0;
        end else if (exec) begin
            steps_q <= steps_q - SW'(1);
            phase_q <= ~phase_q;
        end
    end

    // Per-edge cell controls; SHIFT_MAC shifts on odd edges, accumulates on even ones
    always_comb begin
        ld_a     = exec && (op_q == OP_LOAD_A);
        ld_b     = exec && (op_q == OP_LOAD_B);
        ld_s     = exec && (op_q == OP_LOAD_S);
        clr_s    = exec && (op_q == OP_CLEAR_S);
        shift_en = exec && ((op_q == OP_SHIFT) || ((op_q == OP_SHIFT_MAC) && !phase_q));
        mac_en   = exec && ((op_q == OP_MAC) || ((op_q == OP_SHIFT_MAC) && phase_q));
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            localparam int PA = flat_lsb(r, c, COLS, PRECISION);
            localparam int PS = flat_lsb(r, c, COLS, OUTPUT_PRECISION);
            logic [PRECISION-1:0] a_above, a_below, a_left, a_right;
            logic [PRECISION-1:0] b_above, b_below, b_left, b_right;

            if (r > 0) begin : g_above
                assign a_above = a_q[r-1][c];
                assign b_above = b_q[r-1][c];
            end else begin : g_above_zero
                assign a_above = '0;
                assign b_above = '0;
            end
            if (r < ROWS - 1) begin : g_below
                assign a_below = a_q[r+1][c];
                assign b_below = b_q[r+1][c];
            end else begin : g_below_zero
                assign a_below = '0;
                assign b_below = '0;
            end
            if (c > 0) begin : g_left
                assign a_left = a_q[r][c-1];
                assign b_left = b_q[r][c-1];
            end else begin : g_left_zero
                assign a_left = '0;
                assign b_left = '0;
            end
            if (c < COLS - 1) begin : g_right
                assign a_right = a_q[r][c+1];
                assign b_right = b_q[r][c+1];
            end else begin : g_right_zero
                assign a_right = '0;
                assign b_right = '0;
            end

            pe_grid_cell #(
                .PRECISION        (PRECISION),
                .OUTPUT_PRECISION (OUTPUT_PRECISION)
            ) u_cell (
                .clk       (CLK),
                .rst_n     (RST_N),
                .load_a    (ld_a),
                .load_b    (ld_b),
                .load_s    (ld_s),
                .clear_s   (clr_s),
                .mac_en    (mac_en),
                .shift_en  (shift_en),
                .shift_sel (sel_q),
                .dir       (dir_q),
                .a_ld      (a_load[PA +: PRECISION]),
                .b_ld      (b_load[PA +: PRECISION]),
                .s_ld      (s_load[PS +: OUTPUT_PRECISION]),
                .a_above   (a_above),
                .a_below   (a_below),
                .a_left    (a_left),
                .a_right   (a_right),
                .b_above   (b_above),
                .b_below   (b_below),
                .b_left    (b_left),
                .b_right   (b_right),
                .a         (a_q[r][c]),
                .b         (b_q[r][c]),
                .s         (s_q[r][c])
            );

            assign A_out[PA +: PRECISION]        = a_q[r][c];
            assign B_out[PA +: PRECISION]        = b_q[r][c];
            assign s_out[PS +: OUTPUT_PRECISION] = s_q[r][c];
        end
    end

endmodule

// File: tb/tb_pe_grid_engine.sv
// Bench for pe_grid_engine: table of directed commands, hand-written
// busy/reset sequences and randomized commands against a plane-level model.
`timescale 1ns/1ps
module tb_pe_grid_engine;

    localparam int ROWS = 4, COLS = 4, P = 8, OP = 32, MAX_SHIFT = 4, CW = 3;
    localparam int N = ROWS * COLS;
    localparam longint S_MAX = 64'sh7FFF_FFFF;
    localparam longint S_MIN = -64'sh8000_0000;

    logic            CLK = 1'b0;
    logic            RST_N = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [2:0]      cmd = '0;
    logic [1:0]      shift_direction = '0;
    logic            image_to_shift = 1'b0;
    logic [CW-1:0]   shift_count = '0;
    logic [N*P-1:0]  a_load = '0, b_load = '0;
    logic [N*OP-1:0] s_load = '0;
    logic [N*P-1:0]  A_out, B_out;
    logic [N*OP-1:0] s_out;
    logic            done, busy;
    logic [1:0]      state_dbg;

    pe_grid_engine dut (
        .CLK(CLK), .RST_N(RST_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .shift_direction(shift_direction), .image_to_shift(image_to_shift),
        .shift_count(shift_count), .a_load(a_load), .b_load(b_load), .s_load(s_load),
        .A_out(A_out), .B_out(B_out), .s_out(s_out), .done(done), .busy(busy),
        .state_dbg(state_dbg)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0, n_total = 0;

    // reference planes and host-side load planes
    int ma[ROWS][COLS], mb[ROWS][COLS], ms[ROWS][COLS];
    int la[ROWS][COLS], lb[ROWS][COLS], ls[ROWS][COLS];

    typedef struct {
        int op, dir, sel, cnt;
        int pat, val, pr, pc;
        int exp_lat;
        int cpl, cr, cc, cval;
    } vec_t;
    vec_t tbl[22];

    task automatic check_int(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("%s FAIL: got %0d (0x%h) want %0d (0x%h)", name, got, got, exp, exp);
    endtask

    task automatic check_vec(input string name, input logic [N*OP-1:0] got, input logic [N*OP-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("%s FAIL: got %h want %h", name, got, exp);
    endtask

    function automatic logic [N*OP-1:0] exp_small(input bit is_b);
        logic [N*OP-1:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*P +: P] = is_b ? mb[r][c][P-1:0] : ma[r][c][P-1:0];
        return v;
    endfunction

    function automatic logic [N*OP-1:0] exp_s();
        logic [N*OP-1:0] v;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                v[(r*COLS+c)*OP +: OP] = ms[r][c];
        return v;
    endfunction

    function automatic int dut_el(input int pl, input int r, input int c);
        if (pl == 1) return int'($signed(A_out[(r*COLS+c)*P +: P]));
        if (pl == 2) return int'($signed(B_out[(r*COLS+c)*P +: P]));
        return int'($signed(s_out[(r*COLS+c)*OP +: OP]));
    endfunction

    task automatic check_planes(input string tag);
        check_vec({tag, "_A"}, {{(N*(OP-P)){1'b0}}, A_out}, exp_small(1'b0));
        check_vec({tag, "_B"}, {{(N*(OP-P)){1'b0}}, B_out}, exp_small(1'b1));
        check_vec({tag, "_S"}, s_out, exp_s());
    endtask

    task automatic drive_loads();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                a_load[(r*COLS+c)*P +: P]   = la[r][c][P-1:0];
                b_load[(r*COLS+c)*P +: P]   = lb[r][c][P-1:0];
                s_load[(r*COLS+c)*OP +: OP] = ls[r][c];
            end
    endtask

    task automatic model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                ma[r][c] = 0; mb[r][c] = 0; ms[r][c] = 0;
            end
    endtask

    // move the chosen plane one cell; vacated cells become 0
    task automatic m_shift(input int dir, input int sel);
        int t[ROWS][COLS];
        int sr, sc, v;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) t[r][c] = (sel != 0) ? mb[r][c] : ma[r][c];
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                sr = r; sc = c;
                case (dir)
                    0: sr = r + 1;
                    1: sr = r - 1;
                    2: sc = c + 1;
                    default: sc = c - 1;
                endcase
                v = (sr >= 0 && sr < ROWS && sc >= 0 && sc < COLS) ? t[sr][sc] : 0;
                if (sel != 0) mb[r][c] = v; else ma[r][c] = v;
            end
    endtask

    task automatic m_mac();
        longint sum;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                sum = longint'(ms[r][c]) + longint'(ma[r][c]) * longint'(mb[r][c]);
`ifdef PE_GRID_SATURATE_EN
                if (sum > S_MAX) sum = S_MAX;
                else if (sum < S_MIN) sum = S_MIN;
`endif
                ms[r][c] = sum[31:0];
            end
    endtask

    task automatic m_exec(input int op, input int dir, input int sel, input int cnt);
        int n;
        n = (cnt > MAX_SHIFT) ? MAX_SHIFT : cnt;
        case (op)
            1: ma = la;
            2: mb = lb;
            3: ms = ls;
            4: for (int i = 0; i < n; i++) m_shift(dir, sel);
            5: m_mac();
            6: for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) ms[r][c] = 0;
            7: if (n == 0) m_mac();
               else for (int i = 0; i < n; i++) begin m_shift(dir, sel); m_mac(); end
            default: ;
        endcase
    endtask

    function automatic int exp_latency(input int op, input int cnt);
        int n;
        n = (cnt > MAX_SHIFT) ? MAX_SHIFT : cnt;
        if (op == 4 && n > 0) return n + 1;
        if (op == 7 && n > 0) return 2 * n + 1;
        return 2;
    endfunction

    // Issue one command, measure accept-cycle-to-done latency, compare planes
    task automatic do_cmd(input int op, input int dir, input int sel, input int cnt,
                          input int exp_lat, input bit poke);
        int lat;
        bit seen;
        @(negedge CLK);
        check_int("ready_before_cmd", int'(cmd_ready), 1);
        cmd = op[2:0]; shift_direction = dir[1:0]; image_to_shift = sel[0];
        shift_count = cnt[CW-1:0]; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        check_int("busy_after_accept", int'(busy), 1);
        check_int("ready_after_accept", int'(cmd_ready), 0);
        lat = 1; seen = 1'b0;
        while (!seen && lat < 40) begin
            if (poke && lat == 2) begin cmd_valid = 1'b1; cmd = 3'd5; end
            if (poke && lat == 4) cmd_valid = 1'b0;
            @(posedge CLK); #1;
            lat++;
            if (done) seen = 1'b1;
        end
        cmd_valid = 1'b0;
        check_int("done_seen", int'(seen), 1);
        check_int("latency", lat, exp_lat);
        m_exec(op, dir, sel, cnt);
        check_planes("planes");
        @(posedge CLK); #1;
        check_int("done_one_cycle", int'(done), 0);
        check_int("ready_after_done", int'(cmd_ready), 1);
    endtask

    function automatic vec_t mk(input int op, input int dir, input int sel, input int cnt,
                                input int pat, input int val, input int pr, input int pc,
                                input int lat, input int cpl, input int cr, input int cc,
                                input int cval);
        vec_t v;
        v.op = op; v.dir = dir; v.sel = sel; v.cnt = cnt;
        v.pat = pat; v.val = val; v.pr = pr; v.pc = pc;
        v.exp_lat = lat; v.cpl = cpl; v.cr = cr; v.cc = cc; v.cval = cval;
        return v;
    endfunction

    task automatic apply_pattern(input vec_t v);
        int x;
        if (v.pat == 0) return;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                if (v.pat == 1)      x = r * 4 + c;
                else if (v.pat == 2) x = v.val;
                else                 x = (r == v.pr && c == v.pc) ? v.val : 0;
                if (v.op == 1) la[r][c] = x;
                else if (v.op == 2) lb[r][c] = x;
                else ls[r][c] = x;
            end
        drive_loads();
    endtask

    initial begin
        int sat_exp;
        int op, cnt;
        bit seen;
        vec_t v;

`ifdef PE_GRID_SATURATE_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = 32'h8000_3EF1;
`endif
        //          op dir sel cnt pat val        pr pc lat cpl cr cc cval
        tbl[0]  = mk(1, 0, 0, 0, 1, 0,          0, 0, 2, 1, 2, 3, 11);
        tbl[1]  = mk(1, 0, 0, 0, 2, 3,          0, 0, 2, 1, 0, 0, 3);
        tbl[2]  = mk(2, 0, 0, 0, 2, -2,         0, 0, 2, 2, 3, 3, -2);
        tbl[3]  = mk(5, 0, 0, 0, 0, 0,          0, 0, 2, 3, 0, 0, -6);
        tbl[4]  = mk(5, 0, 0, 0, 0, 0,          0, 0, 2, 3, 2, 1, -12);
        tbl[5]  = mk(1, 0, 0, 0, 3, 5,          1, 1, 2, 1, 1, 1, 5);
        tbl[6]  = mk(4, 3, 0, 2, 0, 0,          0, 0, 3, 1, 1, 3, 5);
        tbl[7]  = mk(4, 3, 0, 1, 0, 0,          0, 0, 2, 1, 1, 3, 0);
        tbl[8]  = mk(6, 0, 0, 0, 0, 0,          0, 0, 2, 3, 2, 1, 0);
        tbl[9]  = mk(2, 0, 0, 0, 2, 1,          0, 0, 2, 2, 0, 0, 1);
        tbl[10] = mk(1, 0, 0, 0, 3, 7,          0, 3, 2, 1, 0, 3, 7);
        tbl[11] = mk(7, 2, 0, 3, 0, 0,          0, 0, 7, 3, 0, 1, 7);
        tbl[12] = mk(4, 0, 1, 7, 0, 0,          0, 0, 5, 2, 0, 0, 0);
        tbl[13] = mk(2, 0, 0, 0, 2, 2,          0, 0, 2, 2, 1, 1, 2);
        tbl[14] = mk(7, 1, 0, 0, 0, 0,          0, 0, 2, 3, 0, 0, 21);
        tbl[15] = mk(4, 1, 0, 0, 0, 0,          0, 0, 2, 1, 0, 0, 7);
        tbl[16] = mk(0, 0, 0, 0, 0, 0,          0, 0, 2, 1, 0, 0, 7);
        tbl[17] = mk(3, 0, 0, 0, 2, 32'h7FFFFFF0, 0, 0, 2, 3, 1, 2, 32'h7FFFFFF0);
        tbl[18] = mk(1, 0, 0, 0, 2, 127,        0, 0, 2, 1, 3, 3, 127);
        tbl[19] = mk(2, 0, 0, 0, 2, 127,        0, 0, 2, 2, 3, 3, 127);
        tbl[20] = mk(5, 0, 0, 0, 0, 0,          0, 0, 2, 3, 2, 2, sat_exp);
        tbl[21] = mk(4, 1, 1, 1, 0, 0,          0, 0, 2, 2, 0, 1, 0);

        // reset state
        model_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin la[r][c] = 0; lb[r][c] = 0; ls[r][c] = 0; end
        repeat (3) @(posedge CLK);
        #1;
        check_planes("reset");
        check_int("reset_ready", int'(cmd_ready), 1);
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_int("reset_state_dbg", int'(state_dbg), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // directed table
        for (int i = 0; i < 22; i++) begin
            v = tbl[i];
            apply_pattern(v);
            do_cmd(v.op, v.dir, v.sel, v.cnt, v.exp_lat, 1'b0);
            if (v.cpl != 0) check_int($sformatf("tbl%0d_cell", i), dut_el(v.cpl, v.cr, v.cc), v.cval);
        end

        // MAC offered during a 4-step shift must be ignored
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin la[r][c] = r + c + 1; lb[r][c] = 2; end
        drive_loads();
        do_cmd(1, 0, 0, 0, 2, 1'b0);
        do_cmd(2, 0, 0, 0, 2, 1'b0);
        do_cmd(4, 3, 0, 4, 5, 1'b1);

        // reset in the middle of a shift aborts it without done
        @(negedge CLK);
        cmd = 3'd4; shift_direction = 2'd3; image_to_shift = 1'b0; shift_count = 3'd4;
        cmd_valid = 1'b1;
        @(posedge CLK); #1;
        cmd_valid = 1'b0;
        @(posedge CLK); @(posedge CLK);
        #2 RST_N = 1'b0;
        #1;
        model_clear();
        check_planes("midreset");
        check_int("midreset_ready", int'(cmd_ready), 1);
        check_int("midreset_done", int'(done), 0);
        @(negedge CLK);
        cmd = 3'd1; cmd_valid = 1'b1;
        @(posedge CLK); #1;
        check_int("no_accept_in_reset", int'(busy), 0);
        cmd_valid = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(posedge CLK); #1;
            if (done) seen = 1'b1;
        end
        check_int("no_done_after_abort", int'(seen), 0);
        check_planes("after_abort");

        // randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) begin
                    la[r][c] = int'($urandom_range(0, 255)) - 128;
                    lb[r][c] = int'($urandom_range(0, 255)) - 128;
                    ls[r][c] = int'($urandom);
                end
            drive_loads();
            op  = int'($urandom_range(0, 7));
            cnt = int'($urandom_range(0, 7));
            do_cmd(op, int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), cnt,
                   exp_latency(op, cnt), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // hard stop if anything above stalls
    initial begin
        #200000;
        $display("global_timeout FAIL: got stuck want completion");
        $fatal(1);
    end

endmodule

// File: doc/pe_grid_engine.md
# pe_grid_engine

Parametrised successor to the message-passing PE array: a ROWS x COLS grid of processing cells holding two image planes (A, B) and a signed accumulator plane (S). Commands arrive over a valid/ready handshake and are sequenced internally. Multi-step shift and shift-then-accumulate operations run without host intervention. Edges are zero-filled in hardware, so the grid needs no padded extension ring; it sits between the host command interface and the output readout.

## Interface
- ROWS, 4: grid rows (>=1)
- COLS, 4: grid columns (>=1)
- PRECISION, 8: A/B element width, signed two's complement
- OUTPUT_PRECISION, 32: S element width; must be >= 2*PRECISION
- MAX_SHIFT, 4: largest legal shift_count; CW = $clog2(MAX_SHIFT+1)

Ports. Flat buses pack element (r,c) at [(r*COLS+c)*W +: W].
- CLK  in  1  clock, all state on rising edge
- RST_N  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high exactly when FSM is IDLE
- cmd  in  3  opcode: 0 NOP, 1 LOAD_A, 2 LOAD_B, 3 LOAD_S, 4 SHIFT, 5 MAC, 6 CLEAR_S, 7 SHIFT_MAC
- shift_direction  in  2  0 up, 1 down, 2 left, 3 right
- image_to_shift  in  1  0 = A plane, 1 = B plane
- shift_count  in  CW  iteration count N
- a_load, b_load  in  ROWS*COLS*PRECISION  load data
- s_load  in  ROWS*COLS*OUTPUT_PRECISION  load data
- A_out, B_out  out  ROWS*COLS*PRECISION  current planes
- s_out  out  ROWS*COLS*OUTPUT_PRECISION  current accumulators
- done  out  1  one-cycle pulse on command completion
- busy  out  1  high when not IDLE

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE -> EXEC on cmd_valid && cmd_ready (accept edge E0).
  - cmd, shift_direction, image_to_shift and shift_count are captured at E0.
  - A shift_count > MAX_SHIFT is clamped to MAX_SHIFT.
- EXEC performs operations on edges E1..Ek, then goes to DONE.
- DONE lasts one cycle, with done=1, then returns to IDLE.
- Single-step commands, k=1:
  - NOP: no change.
  - LOAD_A, LOAD_B, LOAD_S: write the whole plane from the load bus sampled at E1. The host holds load data from accept until done.
  - MAC: every cell performs S += A*B.
  - CLEAR_S: all S set to 0.
- SHIFT, N>=1, k=N: the selected plane moves one cell per edge in shift_direction.
  - Up: row r takes row r+1; the last row gets 0.
  - Down: row r takes row r-1; row 0 gets 0.
  - Left: col c takes col c+1; the last col gets 0.
  - Right: col c takes col c-1; col 0 gets 0.
  - N=0: k=1, no change.
- SHIFT_MAC, N>=1, k=2N: odd edges shift the selected plane, even edges run MAC using the post-shift values.
  - N=0: k=1, single MAC.
- Arithmetic: signed PRECISION x PRECISION product, sign-extended to OUTPUT_PRECISION and added. The sum wraps modulo 2^OUTPUT_PRECISION.
- cmd_valid outside IDLE is ignored. There is no queue; the host re-presents the command.

## Timing
- Reset (async assert, sync-safe release): all A, B, S = 0; state IDLE; done=0; busy=0; cmd_ready=1.
  - No command is accepted while RST_N is low.
  - Reset mid-command aborts it with no done pulse.
- Latency from accept edge to done-high cycle is k+1 cycles. Back-to-back single-step commands run one per 3 cycles.
- A_out, B_out and s_out are registered outputs that change only on operation edges.
- cmd_ready, busy and done are decoded from registered state; no combinational path exists from cmd_valid.

## Configuration
- PE_GRID_SATURATE_EN defined: accumulation saturates to signed OUTPUT_PRECISION max/min instead of wrapping.
- Undefined: modular wrap. All other behaviour is identical.

## Structure
- pe_grid_pkg holds:
  - the opcode enum
  - the FSM state enum
  - direction constants
  - the flat-bus index helper function
- Sub-module pe_grid_cell, instantiated ROWS*COLS times. Each cell:
  - holds its A, B and S registers
  - has a four-neighbour input mux with zero-fill selected at the edges
  - contains the MAC, with saturation under the macro
- The top level owns the FSM, the iteration counter and the edge zero tie-offs.

## Test plan
- Reset, then LOAD_A with a_load element (r,c)=r*4+c on the 4x4 default -> done after 2 cycles; A_out matches; B_out and s_out are 0.
- Load A=3, B=-2 everywhere, then MAC twice -> every S = -12; done pulses once per command.
- A with a single 5 at (1,1); SHIFT right N=2 -> 5 at (1,3), all other cells 0. A further SHIFT right N=1 -> plane all 0. done arrives 3 cycles after accept.
- B=1 everywhere, A with a 7 at (0,3); SHIFT_MAC left N=3 on A -> S(0,2)=7, S(0,1)=7, S(0,0)=7, other S 0; done 7 cycles after accept.
- Assert cmd_valid with MAC during SHIFT N=4 -> not accepted and no extra accumulation. Pulse RST_N low mid-shift -> all planes 0, no done, cmd_ready=1.
- LOAD_S 0x7FFFFFF0, A=B=127, MAC -> with PE_GRID_SATURATE_EN, S=0x7FFFFFFF; without it, S=0x80003EF1.
